mult_sequencer: RTL

Sequential signed-magnitude multiplier controller for the keypad multiplier path. It sits between the operand-capture controller and the display stage. It accepts the two captured magnitudes and their sign bits on a single-cycle `valid`, then runs a shift-and-add multiply over `WIDTH` iterations. It holds the signed-magnitude product with `done` until the display side acknowledges it.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_shift_add.sv | 41 ++++
 rtl/mult_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the keypad multiplier path.
// Holds the sequencer state enum, default operand width and BCD operand limit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } mult_state_t;

  localparam int MULT_WIDTH_DEF = 8;
  localparam int MULT_MAX_BCD   = 99;

endpackage

// File: rtl/mult_shift_add.sv
// Shift-and-add datapath: multiplicand, multiplier and accumulator registers.
// Ports: clk, rst, load/step strobes, numero1/numero2 in, acc out, mult_zero out.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   numero1,
  input  logic [WIDTH-1:0]   numero2,
  output logic [2*WIDTH-1:0] acc,
  output logic               mult_zero
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, numero1};
      mplier <= numero2;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // True when this iteration leaves no set bits in the multiplier.
  assign mult_zero = ((mplier >> 1) == '0);

endmodule

// File: rtl/mult_sequencer.sv
// Signed-magnitude sequential multiplier controller (FSM, counter, sign).
// Ports: clk, rst, valid, numero1/2, signo1/2, ack -> busy, done, producto, signo_res.
// Option: MULT_SEQ_EARLY_EXIT_EN ends CALC once the multiplier runs out of bits.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [WIDTH-1:0]   numero1,
  input  logic [WIDTH-1:0]   numero2,
  input  logic               signo1,
  input  logic               signo2,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] producto,
  output logic               signo_res
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef MULT_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mult_state_t        state;
  logic [CW-1:0]      cnt;
  logic               sign_r;
  logic [2*WIDTH-1:0] acc;
  logic               mult_zero;
  logic               load;
  logic               step;
  logic               last;

  assign load = (state == LOAD);
  assign step = (state == CALC);
  assign last = (cnt == CW'(1)) || (EARLY && mult_zero);

  mult_shift_add #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .numero1  (numero1),
    .numero2  (numero2),
    .acc      (acc),
    .mult_zero(mult_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          sign_r <= signo1 ^ signo2;
          cnt    <= CW'(WIDTH);
          state  <= CALC;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign producto  = acc;
  // No negative zero.
  assign signo_res = sign_r & (|acc);

endmodule
